// File: rtl/ycbcr_pkg.sv
// Shared constants for the YCbCr-to-RGB stream: matrix coefficients for
// BT.601/BT.709, mode encodings and studio-range offset helpers.
package ycbcr_pkg;

  localparam logic MODE_BT601 = 1'b0;
  localparam logic MODE_BT709 = 1'b1;

  localparam real C601_Y  = 1.164;
  localparam real C601_RV = 1.596;
  localparam real C601_GV = 0.813;
  localparam real C601_GU = 0.392;
  localparam real C601_BU = 2.017;

  localparam real C709_Y  = 1.164;
  localparam real C709_RV = 1.793;
  localparam real C709_GV = 0.533;
  localparam real C709_GU = 0.213;
  localparam real C709_BU = 2.112;

  // round(c * 2^frac) for positive coefficient magnitudes
  function automatic int coef_fixed(input real c, input int frac);
    return $rtoi(c * $itor(1 << frac) + 0.5);
  endfunction

  function automatic int y_offset(input int dw);
    return 16 << (dw - 8);
  endfunction

  function automatic int c_offset(input int dw);
    return 128 << (dw - 8);
  endfunction

endpackage

// File: rtl/csc_clip.sv
// One output channel of the colour-space converter: round the fixed-point
// accumulator to an integer and saturate it to [0, 2^DW-1].
module csc_clip #(
  parameter int AW   = 26,
  parameter int DW   = 8,
  parameter int FRAC = 12
) (
  input  logic signed [AW-1:0] acc_i,
  output logic [DW-1:0]        pix_o,
  output logic                 clip_o
);

  localparam logic signed [AW-1:0] HALF = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW){1'b0}}, {DW{1'b1}}};

  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] a);
    return (a + HALF) >>> FRAC;
  endfunction

  // Returns {clipped, pixel}
  function automatic logic [DW:0] saturate(input logic signed [AW-1:0] v);
    if (v[AW-1]) begin
      return {1'b1, {DW{1'b0}}};
    end else if (v > MAXV) begin
      return {1'b1, {DW{1'b1}}};
    end else begin
      return {1'b0, v[DW-1:0]};
    end
  endfunction

  always_comb begin
    {clip_o, pix_o} = saturate(round_shift(acc_i));
  end

endmodule

// File: rtl/ycbcr_to_rgb_stream.sv
// Streaming studio-range YCbCr 4:4:4 to full-range RGB, 3-stage pipeline with
// valid/ready backpressure. Define CSC_CLIP_COUNT_EN to add the clip counter.
module ycbcr_to_rgb_stream #(
  parameter int DW   = 8,
  parameter int FRAC = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_y,
  input  logic [DW-1:0] in_cb,
  input  logic [DW-1:0] in_cr,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_red,
  output logic [DW-1:0] out_green,
  output logic [DW-1:0] out_blue,
  output logic          out_sop,
  output logic          out_eop
`ifdef CSC_CLIP_COUNT_EN
  ,
  input  logic          clip_clear,
  output logic [15:0]   clip_count
`endif
);
  import ycbcr_pkg::*;

  localparam int IW = DW + 1;
  localparam int AW = DW + FRAC + 6;

  localparam logic signed [IW-1:0] Y_OFF = IW'(y_offset(DW));
  localparam logic signed [IW-1:0] C_OFF = IW'(c_offset(DW));

  localparam logic signed [AW-1:0] K_Y     = AW'(coef_fixed(C601_Y,  FRAC));
  localparam logic signed [AW-1:0] K601_RV = AW'(coef_fixed(C601_RV, FRAC));
  localparam logic signed [AW-1:0] K601_GV = AW'(coef_fixed(C601_GV, FRAC));
  localparam logic signed [AW-1:0] K601_GU = AW'(coef_fixed(C601_GU, FRAC));
  localparam logic signed [AW-1:0] K601_BU = AW'(coef_fixed(C601_BU, FRAC));
  localparam logic signed [AW-1:0] K709_RV = AW'(coef_fixed(C709_RV, FRAC));
  localparam logic signed [AW-1:0] K709_GV = AW'(coef_fixed(C709_GV, FRAC));
  localparam logic signed [AW-1:0] K709_GU = AW'(coef_fixed(C709_GU, FRAC));
  localparam logic signed [AW-1:0] K709_BU = AW'(coef_fixed(C709_BU, FRAC));

  logic ce, accept;
  logic mode_q, mode_d;

  logic                 vld_p0_q, vld_p0_d, sop_p0_q, sop_p0_d, eop_p0_q, eop_p0_d;
  logic signed [IW-1:0] y_p0_q, y_p0_d, cb_p0_q, cb_p0_d, cr_p0_q, cr_p0_d;

  logic                 vld_p1_q, vld_p1_d, sop_p1_q, sop_p1_d, eop_p1_q, eop_p1_d;
  logic signed [AW-1:0] acc_r_p1_q, acc_r_p1_d, acc_g_p1_q, acc_g_p1_d, acc_b_p1_q, acc_b_p1_d;

  logic                 vld_p2_q, vld_p2_d, sop_p2_q, sop_p2_d, eop_p2_q, eop_p2_d;
  logic [DW-1:0]        red_p2_q, red_p2_d, green_p2_q, green_p2_d, blue_p2_q, blue_p2_d;

  logic signed [AW-1:0] y_ext, cb_ext, cr_ext, k_rv, k_gv, k_gu, k_bu;
  logic signed [AW-1:0] acc_r_c, acc_g_c, acc_b_c;
  logic [DW-1:0]        red_c, green_c, blue_c;
  logic [2:0]           clip_c;

  csc_clip #(.AW(AW), .DW(DW), .FRAC(FRAC)) u_clip_r (
    .acc_i(acc_r_p1_q), .pix_o(red_c),   .clip_o(clip_c[0]));
  csc_clip #(.AW(AW), .DW(DW), .FRAC(FRAC)) u_clip_g (
    .acc_i(acc_g_p1_q), .pix_o(green_c), .clip_o(clip_c[1]));
  csc_clip #(.AW(AW), .DW(DW), .FRAC(FRAC)) u_clip_b (
    .acc_i(acc_b_p1_q), .pix_o(blue_c),  .clip_o(clip_c[2]));

  always_comb begin
    ce     = !vld_p2_q || out_ready;
    accept = in_valid && ce;

    // A frame's matrix is latched by its sop beat and used from that pixel on
    mode_d = mode_q;
    if (accept && in_sop) begin
      mode_d = mode;
    end

    y_ext  = {{(AW-IW){y_p0_q[IW-1]}},  y_p0_q};
    cb_ext = {{(AW-IW){cb_p0_q[IW-1]}}, cb_p0_q};
    cr_ext = {{(AW-IW){cr_p0_q[IW-1]}}, cr_p0_q};
    k_rv   = (mode_q == MODE_BT709) ? K709_RV : K601_RV;
    k_gv   = (mode_q == MODE_BT709) ? K709_GV : K601_GV;
    k_gu   = (mode_q == MODE_BT709) ? K709_GU : K601_GU;
    k_bu   = (mode_q == MODE_BT709) ? K709_BU : K601_BU;

    acc_r_c = y_ext * K_Y + cr_ext * k_rv;
    acc_g_c = y_ext * K_Y - cr_ext * k_gv - cb_ext * k_gu;
    acc_b_c = y_ext * K_Y + cb_ext * k_bu;

    vld_p0_d = vld_p0_q; sop_p0_d = sop_p0_q; eop_p0_d = eop_p0_q;
    y_p0_d   = y_p0_q;   cb_p0_d  = cb_p0_q;  cr_p0_d  = cr_p0_q;
    vld_p1_d = vld_p1_q; sop_p1_d = sop_p1_q; eop_p1_d = eop_p1_q;
    acc_r_p1_d = acc_r_p1_q; acc_g_p1_d = acc_g_p1_q; acc_b_p1_d = acc_b_p1_q;
    vld_p2_d = vld_p2_q; sop_p2_d = sop_p2_q; eop_p2_d = eop_p2_q;
    red_p2_d = red_p2_q; green_p2_d = green_p2_q; blue_p2_d = blue_p2_q;

    if (ce) begin
      // S1: remove studio-range offsets
      vld_p0_d = in_valid;
      sop_p0_d = in_sop;
      eop_p0_d = in_eop;
      y_p0_d   = $signed({1'b0, in_y})  - Y_OFF;
      cb_p0_d  = $signed({1'b0, in_cb}) - C_OFF;
      cr_p0_d  = $signed({1'b0, in_cr}) - C_OFF;
      // S2: matrix multiply-accumulate
      vld_p1_d   = vld_p0_q;
      sop_p1_d   = sop_p0_q;
      eop_p1_d   = eop_p0_q;
      acc_r_p1_d = acc_r_c;
      acc_g_p1_d = acc_g_c;
      acc_b_p1_d = acc_b_c;
      // S3: round, clip, register outputs
      vld_p2_d   = vld_p1_q;
      sop_p2_d   = sop_p1_q;
      eop_p2_d   = eop_p1_q;
      red_p2_d   = red_c;
      green_p2_d = green_c;
      blue_p2_d  = blue_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_BT601;
      vld_p0_q   <= 1'b0;
      sop_p0_q   <= 1'b0;
      eop_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      sop_p1_q   <= 1'b0;
      eop_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      sop_p2_q   <= 1'b0;
      eop_p2_q   <= 1'b0;
      red_p2_q   <= '0;
      green_p2_q <= '0;
      blue_p2_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      vld_p0_q   <= vld_p0_d;
      sop_p0_q   <= sop_p0_d;
      eop_p0_q   <= eop_p0_d;
      vld_p1_q   <= vld_p1_d;
      sop_p1_q   <= sop_p1_d;
      eop_p1_q   <= eop_p1_d;
      vld_p2_q   <= vld_p2_d;
      sop_p2_q   <= sop_p2_d;
      eop_p2_q   <= eop_p2_d;
      red_p2_q   <= red_p2_d;
      green_p2_q <= green_p2_d;
      blue_p2_q  <= blue_p2_d;
    end
  end

  // Intermediate datapath registers carry no reset; their valid bits gate them
  always_ff @(posedge clk) begin
    y_p0_q     <= y_p0_d;
    cb_p0_q    <= cb_p0_d;
    cr_p0_q    <= cr_p0_d;
    acc_r_p1_q <= acc_r_p1_d;
    acc_g_p1_q <= acc_g_p1_d;
    acc_b_p1_q <= acc_b_p1_d;
  end

`ifdef CSC_CLIP_COUNT_EN
  logic        clip_p2_q, clip_p2_d;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_p2_d = clip_p2_q;
    if (ce) begin
      clip_p2_d = |clip_c;
    end
    clip_cnt_d = clip_cnt_q;
    if (clip_clear) begin
      clip_cnt_d = '0;
    end else if (vld_p2_q && out_ready && clip_p2_q && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_p2_q  <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      clip_p2_q  <= clip_p2_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_count = clip_cnt_q;
`else
  logic clip_unused;
  assign clip_unused = |clip_c;
`endif

  assign in_ready  = ce;
  assign out_valid = vld_p2_q;
  assign out_red   = red_p2_q;
  assign out_green = green_p2_q;
  assign out_blue  = blue_p2_q;
  assign out_sop   = sop_p2_q;
  assign out_eop   = eop_p2_q;

endmodule

// File: tb/tb_ycbcr_to_rgb_stream.sv
// Scoreboard bench for ycbcr_to_rgb_stream (DW=8, FRAC=12); exercises the
// clip counter too when CSC_CLIP_COUNT_EN is defined.
module tb_ycbcr_to_rgb_stream;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_y = '0, in_cb = '0, in_cr = '0;
  logic       in_sop = 1'b0, in_eop = 1'b0, mode = 1'b0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_red, out_green, out_blue;
  logic       out_sop, out_eop;
`ifdef CSC_CLIP_COUNT_EN
  logic        clip_clear = 1'b0;
  logic [15:0] clip_count;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic stall_prev = 1'b0;
  exp_t held;

  ycbcr_to_rgb_stream #(.DW(8), .FRAC(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr),
    .in_sop(in_sop), .in_eop(in_eop), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_sop(out_sop), .out_eop(out_eop)
`ifdef CSC_CLIP_COUNT_EN
    , .clip_clear(clip_clear), .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] clamp8(input longint v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Fixed-point reference with hand-quantised FRAC=12 coefficients
  function automatic exp_t model(input logic [7:0] y, cb, cr, input logic m, sop, eop);
    longint yy, uu, vv, ky, krv, kgv, kgu, kbu;
    exp_t e;
    yy = longint'(y) - 16;
    uu = longint'(cb) - 128;
    vv = longint'(cr) - 128;
    ky = 4768;
    if (m) begin
      krv = 7344; kgv = 2183; kgu = 872;  kbu = 8651;
    end else begin
      krv = 6537; kgv = 3330; kgu = 1606; kbu = 8262;
    end
    e.sop = sop;
    e.eop = eop;
    e.r = clamp8((ky * yy + krv * vv + 2048) >>> 12);
    e.g = clamp8((ky * yy - kgv * vv - kgu * uu + 2048) >>> 12);
    e.b = clamp8((ky * yy + kbu * uu + 2048) >>> 12);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t obs, e;
    obs = {out_sop, out_eop, out_red, out_green, out_blue};
    if (stall_prev) begin
      chk("hold_stable", 32'(obs), 32'(held));
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_beat observed=0x%0h expected=none", obs);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat", 32'(obs), 32'(e));
      end
    end
    stall_prev = out_valid && !out_ready && !rst;
    held = obs;
  end

  task automatic send(input logic [7:0] y, cb, cr, input logic sop, eop, m, input exp_t e);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    in_y = y; in_cb = cb; in_cr = cr; in_sop = sop; in_eop = eop; mode = m;
    in_valid = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=no_ready expected=accept");
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] sy[20], scb[20], scr[20];
    logic       smode[20];
    int         lat, sent, c;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outputs", 32'({out_sop, out_eop, out_red, out_green, out_blue}), 32'd0);
`ifdef CSC_CLIP_COUNT_EN
    chk("reset_clip_count", 32'(clip_count), 32'd0);
`endif

    // Black with sop, and its latency
    send(8'd16, 8'd128, 8'd128, 1'b1, 1'b0, 1'b0, '{1'b1, 1'b0, 8'd0, 8'd0, 8'd0});
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    send(8'd235, 8'd128, 8'd128, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 8'd255, 8'd255, 8'd255});
    send(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 8'd74,  8'd255, 8'd20});
    send(8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b1, 8'd255, 8'd125, 8'd255});
    wait_drain("drain_patterns");

`ifdef CSC_CLIP_COUNT_EN
    chk("clip_count_two", 32'(clip_count), 32'd2);
    send(8'd255, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, '{1'b1, 1'b1, 8'd74, 8'd255, 8'd20});
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    clip_clear = 1'b1;
    @(posedge clk); #1;
    clip_clear = 1'b0;
    chk("clip_clear_wins", 32'(clip_count), 32'd0);
    wait_drain("drain_clip");
`endif

    // Matrix switch on sop; mode ignored mid-frame
    send(8'd128, 8'd128, 8'd240, 1'b1, 1'b1, 1'b0, '{1'b1, 1'b1, 8'd255, 8'd39, 8'd130});
    send(8'd128, 8'd128, 8'd240, 1'b1, 1'b0, 1'b1, '{1'b1, 1'b0, 8'd255, 8'd71, 8'd130});
    send(8'd128, 8'd128, 8'd240, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 8'd255, 8'd71, 8'd130});
    send(8'd128, 8'd128, 8'd240, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b1, 8'd255, 8'd71, 8'd130});
    wait_drain("drain_mode");

    // Random frame with a backpressure window
    for (int i = 0; i < 20; i++) begin
      sy[i]    = 8'($urandom_range(0, 255));
      scb[i]   = 8'($urandom_range(0, 255));
      scr[i]   = 8'($urandom_range(0, 255));
      smode[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    c = 0;
    while (sent < 20 && c < 200) begin
      out_ready = !(c >= 5 && c <= 9);
      in_y = sy[sent]; in_cb = scb[sent]; in_cr = scr[sent];
      in_sop = (sent == 0); in_eop = (sent == 19); mode = smode[sent];
      in_valid = 1'b1;
      @(negedge clk);
      if (c >= 5 && c <= 9) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (in_ready) begin
        sb.push_back(model(sy[sent], scb[sent], scr[sent], smode[0], sent == 0, sent == 19));
        sent++;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", 32'(sent), 32'd20);
    wait_drain("drain_stream");

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_y = 8'(100 + i); in_cb = 8'd90; in_cr = 8'd200;
      in_sop = (i == 0); in_eop = (i == 2); mode = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_mid_no_stale", 32'(out_valid), 32'd0);

    // Mode register back to BT.601 after reset
    send(8'd128, 8'd128, 8'd240, 1'b0, 1'b0, 1'b0, '{1'b0, 1'b0, 8'd255, 8'd39, 8'd130});
    wait_drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ycbcr_to_rgb_stream.md
Name: ycbcr_to_rgb_stream

Overview:
- Parametrised, streaming successor to the fixed 8-bit YCbCr-to-RGB converter.
- Converts studio-range YCbCr 4:4:4 pixels to full-range RGB.
- Data width and coefficient precision are configurable; BT.601 or BT.709 matrix is selectable per frame.
- Uses valid/ready handshakes with full backpressure and passes sop/eop framing through.
- Sits between the chroma upsampler and the display/scaler pipeline.

Parameters:
- DW, 8, bits per component on input and output (8..12).
- FRAC, 12, fractional bits of the fixed-point coefficients (10..16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_y, in_cb, in_cr  in  DW each  input components
- in_sop  in  1  first pixel of a frame
- in_eop  in  1  last pixel of a frame
- mode  in  1  0 = BT.601, 1 = BT.709; sampled only on sop beats
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_red, out_green, out_blue  out  DW each  output components
- out_sop, out_eop  out  1 each  framing, aligned with the pixel

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Pipeline: 3 stages, so latency is 3 cycles from an accepted input beat to out_valid with no stall.
  - S1: subtract offsets. Y − (16<<(DW−8)), Cb − (128<<(DW−8)), Cr − (128<<(DW−8)), all signed, DW+1 bits.
  - S2: multiply-accumulate with the matrix selected by mode_q.
  - S3: round, clip, register the outputs.
- Coefficients: round(c·2^FRAC), unsigned magnitudes with signs applied in the sums.
  - BT.601: 1.164, 1.596, 0.813, 0.392, 2.017.
  - BT.709: 1.164, 1.793, 0.533, 0.213, 2.112.
  - Sums: R = kY·y + kRV·cr; G = kY·y − kGV·cr − kGU·cb; B = kY·y + kBU·cb.
- Rounding: add 2^(FRAC−1), then arithmetic shift right by FRAC.
  - Clip to [0, 2^DW−1].
  - Result must be within ±1 LSB of the real-valued formula after the same clip.
- Mode register: mode_q is loaded from `mode` only when a beat is accepted with in_sop=1. It is constant for the rest of the frame and resets to 0. The S2 matrix select is mode_q as updated by that beat, so the sop pixel uses the new mode.
- Stall: ce = !out_valid | out_ready, and in_ready = ce.
  - When ce=0, every stage register holds; outputs stay stable while out_valid=1 and out_ready=0.
  - Bubbles do not collapse; each stage carries its own valid bit.
  - in_valid=1 with in_ready=0 is not accepted; upstream holds its data.
- Framing: sop and eop travel with their pixel. A beat with sop=eop=1 is legal.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - out_red, out_green, out_blue = 0; out_sop, out_eop = 0; mode_q = 0.
  - in_ready = 1 after reset (ce is true when out_valid = 0).
- Reset mid-stream: in-flight beats are discarded, and out_valid = 0 on the cycle after rst is sampled high.

Optional Feature:
- Macro: CSC_CLIP_COUNT_EN.
- When defined, adds two ports:
  - clip_clear  in  1
  - clip_count  out  16
- clip_count counts output beats transferred (out_valid & out_ready) in which any channel clipped, high or low.
- The counter saturates at 0xFFFF. It clears on rst or clip_clear; if clip_clear and a counted beat occur in the same cycle, clear wins.
- When not defined, the ports and logic are absent; the datapath is identical.

Decomposition:
- Package ycbcr_pkg holds:
  - Coefficient constants for both standards, as real values plus a function that quantises them for a given FRAC.
  - MODE_BT601/MODE_BT709 constants.
  - Offset helper functions parametrised by DW.
- Sub-module csc_clip: round, shift and saturate one channel, parametrised by width and FRAC. It is instantiated three times.

Test Plan (DW=8, FRAC=12, out_ready=1 unless stated):
- Reset then sop beat Y=16, Cb=128, Cr=128, mode=0 → after 3 cycles R,G,B = 0,0,0 with out_sop=1.
- Y=235, Cb=128, Cr=128 → 255,255,255; Y=255, Cb=0, Cr=0 → R=74, G=255, B=20 (±1); Y=255, Cb=255, Cr=255 → R=255, G=125, B=255 (±1).
- Frame 1 with mode=0, then sop with mode=1 and Y=128, Cb=128, Cr=240 → R=255 (clipped) in the 709 frame. Non-sop beats in that frame with mode toggled keep the 709 results.
- Stream 20 random beats with out_ready low for cycles 5–9 → in_ready=0 and outputs held stable throughout; all 20 outputs match the reference model in order, with no loss or duplication.
- Reset asserted while 3 beats are in flight → out_valid=0 on the next cycle; no stale beat appears afterwards.
- With CSC_CLIP_COUNT_EN, stream the three patterns from test 2 → clip_count=2. Pulse clip_clear in the same cycle as a clipped beat → clip_count=0.
